// File: rtl/input_pkg.sv
// Shared definitions for the input conditioner slice.
//
// Contents:
//   clog2         - ceiling log2, used to size the debounce counters
//   clog2_min1    - clog2 clamped to at least 1 bit
//   params_legal  - elaboration-time legality test for the conditioner
//                   parameters (SYNC_STAGES >= 2, DEBOUNCE_CNT >= 1)
package input_pkg;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A counter that only ever holds 0 still needs one physical bit.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = clog2(value);
        return (bits < 1) ? 1 : bits;
    endfunction

    function automatic bit params_legal(input int sync_stages, input int debounce_cnt);
        return (sync_stages >= 2) && (debounce_cnt >= 1);
    endfunction

endpackage

// File: rtl/input_filter_bit.sv
// One channel of the input conditioner: synchroniser chain, debounce
// counter, debounced level and registered rise/fall strobes.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   hold        synchronous hold; forces all state to its reset values
//   din         asynchronous raw input
//   dout        synchronised, debounced level
//   rise, fall  one-cycle strobes when dout goes 0->1 / 1->0
//   strobe_next value rise|fall will take at the next edge, so the
//               parent can register an aligned summary flag
module input_filter_bit
    import input_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_CNT = 4,
    parameter logic RESET_VALUE  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic strobe_next
);

    localparam int CNT_W = clog2_min1(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] chain, chain_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   dout_next, rise_next, fall_next;
    logic                   s;

    assign s           = chain[SYNC_STAGES-1];
    assign strobe_next = rise_next | fall_next;

    // The counter measures how long s has disagreed with dout; it is
    // cleared whenever s falls back to dout, so only an unbroken run of
    // DEBOUNCE_CNT samples is accepted.
    always_comb begin
        chain_next = {chain[SYNC_STAGES-2:0], din};
        cnt_next   = cnt;
        dout_next  = dout;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (hold) begin
            chain_next = {SYNC_STAGES{RESET_VALUE}};
            cnt_next   = '0;
            dout_next  = RESET_VALUE;
        end else if (s == dout) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            dout_next = s;
            cnt_next  = '0;
            rise_next = s;
            fall_next = ~s;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RESET_VALUE}};
            cnt   <= '0;
            dout  <= RESET_VALUE;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= chain_next;
            cnt   <= cnt_next;
            dout  <= dout_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchronises and debounces WIDTH
// asynchronous inputs and produces a synchronised reset for core logic.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   sync_rst_n  downstream reset: asynchronous assert, synchronous release
//   din         raw asynchronous inputs
//   dout        debounced level per channel
//   rise, fall  per-channel one-cycle edge strobes
//   changed     registered OR of all strobes, aligned with them
module input_conditioner
    import input_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               SYNC_STAGES  = 2,
    parameter int               DEBOUNCE_CNT = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             sync_rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    if (!params_legal(SYNC_STAGES, DEBOUNCE_CNT)) begin : g_bad_params
        $error("input_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CNT >= 1");
    end

    logic [SYNC_STAGES-1:0] rst_chain;
    logic [WIDTH-1:0]       strobe_next;
    logic                   hold;

    assign sync_rst_n = rst_chain[SYNC_STAGES-1];
    assign hold       = ~sync_rst_n;

    // Reset synchroniser: cleared instantly by rst_n, then ones walk in
    // so release is always aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_chain <= '0;
        end else begin
            rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        input_filter_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CNT(DEBOUNCE_CNT),
            .RESET_VALUE (RESET_VALUE[i])
        ) u_filter (
            .clk        (clk),
            .rst_n      (rst_n),
            .hold       (hold),
            .din        (din[i]),
            .dout       (dout[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .strobe_next(strobe_next[i])
        );
    end

    // Registered from the channels' next-strobe values so it lines up
    // with rise/fall in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |strobe_next;
        end
    end

endmodule
